// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Round-robin arbiter between the data-memory port and the instruction-fetch port onto a
// single external memory bus. One transaction is outstanding at a time. A grant drives the
// registered bus strobe until bus_ack_i. The winning requester then sees a one-cycle *_good_o
// pulse with its read data on *_rdata_o.
//
// Configuration macro: MEM_ARB_TIMEOUT_EN
//   defined   - a 16-bit watchdog aborts a transaction after TIMEOUT_CYCLES busy cycles
//               without ack. The owner gets *_good_o with 32'hBAD0_BAD0 and timeout_o pulses.
//   undefined - no watchdog, timeout_o is tied low, and BUSY waits for ack indefinitely.
//
// Ports
//   clk_i, rst_i        clock (rising edge), asynchronous active-high reset
//   data_read_i/_write_i, data_adr_i, data_wdata_i   data-side request (level)
//   data_good_o, data_rdata_o                        data-side completion pulse and read data
//   instr_read_i, instr_adr_i                        fetch request (level)
//   instr_good_o, instr_rdata_o                      fetch completion pulse and fetched word
//   bus_read_o, bus_write_o, bus_adr_o, bus_wdata_o  registered bus request
//   bus_ack_i, bus_rdata_i                           bus completion pulse and read data
//   timeout_o                                        one-cycle pulse on watchdog abort
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_read_i,
  input  logic        data_write_i,
  input  logic [31:0] data_adr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_good_o,
  output logic [31:0] data_rdata_o,
  input  logic        instr_read_i,
  input  logic [31:0] instr_adr_i,
  output logic        instr_good_o,
  output logic [31:0] instr_rdata_o,
  output logic        bus_read_o,
  output logic        bus_write_o,
  output logic [31:0] bus_adr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        timeout_o
);

  localparam logic [1:0]  StIdle    = 2'd0;
  localparam logic [1:0]  StBusy    = 2'd1;
  localparam logic [1:0]  StResp    = 2'd2;
  localparam logic        OwnData   = 1'b0;
  localparam logic        OwnInstr  = 1'b1;
  localparam logic [31:0] AbortData = 32'hBAD0_BAD0;

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic        bus_read_q, bus_read_d;
  logic        bus_write_q, bus_write_d;
  logic [31:0] bus_adr_q, bus_adr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic        data_good_q, data_good_d;
  logic        instr_good_q, instr_good_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic [31:0] instr_rdata_q, instr_rdata_d;
  logic [31:0] resp_data;

  logic dreq;
  logic ireq;
  logic grant_instr;
  logic expire;

  assign dreq = data_read_i | data_write_i;
  assign ireq = instr_read_i;

  // With both sides pending, the side that did not win last time goes next.
  assign grant_instr = ireq & (~dreq | (last_grant_q == OwnData));

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        timeout_q;

  // An ack in the expiry cycle takes precedence, so expiry requires no ack.
  assign expire = (state_q == StBusy) && !bus_ack_i && (cnt_q == TimeoutLast);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q != StBusy) begin
      cnt_d = '0;
    end else if (!bus_ack_i) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= expire;
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign expire             = 1'b0;
  assign timeout_o          = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    bus_read_d    = bus_read_q;
    bus_write_d   = bus_write_q;
    bus_adr_d     = bus_adr_q;
    bus_wdata_d   = bus_wdata_q;
    data_good_d   = 1'b0;
    instr_good_d  = 1'b0;
    data_rdata_d  = '0;
    instr_rdata_d = '0;
    resp_data     = '0;

    unique case (state_q)
      StIdle: begin
        if (dreq || ireq) begin
          state_d = StBusy;
          if (grant_instr) begin
            owner_d     = OwnInstr;
            bus_read_d  = 1'b1;
            bus_write_d = 1'b0;
            bus_adr_d   = instr_adr_i;
            bus_wdata_d = '0;
          end else begin
            // Read wins when the data side raises both strobes.
            owner_d     = OwnData;
            bus_read_d  = data_read_i;
            bus_write_d = ~data_read_i;
            bus_adr_d   = data_adr_i;
            bus_wdata_d = data_wdata_i;
          end
        end
      end

      StBusy: begin
        if (bus_ack_i || expire) begin
          state_d     = StResp;
          bus_read_d  = 1'b0;
          bus_write_d = 1'b0;
          if (bus_ack_i) begin
            resp_data = bus_read_q ? bus_rdata_i : '0;
          end else begin
            resp_data = AbortData;
          end
          if (owner_q == OwnInstr) begin
            instr_good_d  = 1'b1;
            instr_rdata_d = resp_data;
          end else begin
            data_good_d  = 1'b1;
            data_rdata_d = resp_data;
          end
        end
      end

      StResp: begin
        state_d      = StIdle;
        last_grant_d = owner_q;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      owner_q       <= OwnData;
      last_grant_q  <= OwnInstr;
      bus_read_q    <= 1'b0;
      bus_write_q   <= 1'b0;
      bus_adr_q     <= '0;
      bus_wdata_q   <= '0;
      data_good_q   <= 1'b0;
      instr_good_q  <= 1'b0;
      data_rdata_q  <= '0;
      instr_rdata_q <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      bus_read_q    <= bus_read_d;
      bus_write_q   <= bus_write_d;
      bus_adr_q     <= bus_adr_d;
      bus_wdata_q   <= bus_wdata_d;
      data_good_q   <= data_good_d;
      instr_good_q  <= instr_good_d;
      data_rdata_q  <= data_rdata_d;
      instr_rdata_q <= instr_rdata_d;
    end
  end

  assign bus_read_o    = bus_read_q;
  assign bus_write_o   = bus_write_q;
  assign bus_adr_o     = bus_adr_q;
  assign bus_wdata_o   = bus_wdata_q;
  assign data_good_o   = data_good_q;
  assign data_rdata_o  = data_rdata_q;
  assign instr_good_o  = instr_good_q;
  assign instr_rdata_o = instr_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: table-driven single transactions, hand-written corner sequences
// (contention, async reset, stray ack, watchdog) and randomized traffic against a
// transaction-level model with a bus-side memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_read, data_write, instr_read;
  logic [31:0] data_adr, data_wdata, instr_adr;
  logic        data_good, instr_good;
  logic [31:0] data_rdata, instr_rdata;
  logic        bus_read, bus_write, bus_ack, timeout;
  logic [31:0] bus_adr, bus_wdata, bus_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .data_read_i  (data_read),
    .data_write_i (data_write),
    .data_adr_i   (data_adr),
    .data_wdata_i (data_wdata),
    .data_good_o  (data_good),
    .data_rdata_o (data_rdata),
    .instr_read_i (instr_read),
    .instr_adr_i  (instr_adr),
    .instr_good_o (instr_good),
    .instr_rdata_o(instr_rdata),
    .bus_read_o   (bus_read),
    .bus_write_o  (bus_write),
    .bus_adr_o    (bus_adr),
    .bus_wdata_o  (bus_wdata),
    .bus_ack_i    (bus_ack),
    .bus_rdata_i  (bus_rdata),
    .timeout_o    (timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    data_read  = 1'b0;
    data_write = 1'b0;
    instr_read = 1'b0;
    data_adr   = '0;
    data_wdata = '0;
    instr_adr  = '0;
    bus_ack    = 1'b0;
    bus_rdata  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " bus_read"},    {31'b0, bus_read},   0);
    chk({tag, " bus_write"},   {31'b0, bus_write},  0);
    chk({tag, " data_good"},   {31'b0, data_good},  0);
    chk({tag, " instr_good"},  {31'b0, instr_good}, 0);
    chk({tag, " data_rdata"},  data_rdata,          0);
    chk({tag, " instr_rdata"}, instr_rdata,         0);
  endtask

  typedef struct {
    logic        dr, dw, ir;
    logic [31:0] dadr, dwdata, iadr;
    int          k;
    logic [31:0] brdata;
    logic        e_rd, e_wr;
    logic [31:0] e_adr, e_wdata;
    logic        e_instr;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[6];
  vec_t v;

  // Random-phase model state
  logic [31:0] mem[16];
  logic        d_pend, d_isrd, d_both, i_pend, last_instr, inflight, exp_i, strobe;
  logic        own_instr, own_rd;
  logic [31:0] d_adr_m, d_wd_m, i_adr_m, own_adr, own_wd, exp_rd;
  int          cd, age, n_done, ng;
  logic [3:0]  widx;
  logic        seen[3];

  initial begin
    //  dr    dw    ir    dadr   dwdata        iadr   k  brdata        rd wr adr  wdata  instr rdata
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 3, 32'hCAFEF00D,
                1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'hCAFEF00D};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h200, 32'h12345678, 32'h0, 1, 32'hDEADBEEF,
                1'b0, 1'b1, 32'h200, 32'h12345678, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFFFFFF, 32'h400, 2, 32'h0BADF00D,
                1'b1, 1'b0, 32'h400, 32'h0, 1'b1, 32'h0BADF00D};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h300, 32'h000055AA, 32'h0, 1, 32'h11112222,
                1'b1, 1'b0, 32'h300, 32'h000055AA, 1'b0, 32'h11112222};
    // Both pending after a data grant: instr wins.
    vecs[4] = '{1'b1, 1'b0, 1'b1, 32'h500, 32'h0, 32'h600, 2, 32'h600D600D,
                1'b1, 1'b0, 32'h600, 32'h0, 1'b1, 32'h600D600D};
    // Both pending after an instr grant: data wins.
    vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h700, 32'hC0FFEE00, 32'h800, 1, 32'h99999999,
                1'b0, 1'b1, 32'h700, 32'hC0FFEE00, 1'b0, 32'h0};

    // Reset state
    rst = 1'b1;
    idle_inputs();
    #2;
    chk_quiet("reset");
    chk("reset bus_adr",   bus_adr,   0);
    chk("reset bus_wdata", bus_wdata, 0);
    chk("reset timeout",   {31'b0, timeout}, 0);
    do_reset();

    // Table-driven single transactions
    for (int i = 0; i < 6; i++) begin
      v          = vecs[i];
      data_read  = v.dr;
      data_write = v.dw;
      instr_read = v.ir;
      data_adr   = v.dadr;
      data_wdata = v.dwdata;
      instr_adr  = v.iadr;
      step();
      for (int c = 1; c <= v.k; c++) begin
        chk($sformatf("v%0d c%0d bus_read", i, c),  {31'b0, bus_read},  {31'b0, v.e_rd});
        chk($sformatf("v%0d c%0d bus_write", i, c), {31'b0, bus_write}, {31'b0, v.e_wr});
        chk($sformatf("v%0d c%0d bus_adr", i, c),   bus_adr,   v.e_adr);
        chk($sformatf("v%0d c%0d bus_wdata", i, c), bus_wdata, v.e_wdata);
        chk($sformatf("v%0d c%0d goods", i, c), {30'b0, data_good, instr_good}, 0);
        if (c == v.k) begin
          bus_ack   = 1'b1;
          bus_rdata = v.brdata;
        end
        step();
      end
      bus_ack   = 1'b0;
      bus_rdata = '0;
      chk($sformatf("v%0d resp strobes", i), {30'b0, bus_read, bus_write}, 0);
      chk($sformatf("v%0d data_good", i),  {31'b0, data_good},  {31'b0, !v.e_instr});
      chk($sformatf("v%0d instr_good", i), {31'b0, instr_good}, {31'b0, v.e_instr});
      chk($sformatf("v%0d data_rdata", i),  data_rdata,  v.e_instr ? 32'h0 : v.e_rdata);
      chk($sformatf("v%0d instr_rdata", i), instr_rdata, v.e_instr ? v.e_rdata : 32'h0);
      chk($sformatf("v%0d timeout", i), {31'b0, timeout}, 0);
      idle_inputs();
      step();
      chk_quiet($sformatf("v%0d after", i));
    end

    // Contention from reset: data, instr, data
    do_reset();
    data_read  = 1'b1;
    instr_read = 1'b1;
    data_adr   = 32'hA0;
    instr_adr  = 32'hB0;
    ng = 0;
    for (int c = 0; c < 40 && ng < 3; c++) begin
      step();
      bus_ack   = bus_read | bus_write;
      bus_rdata = 32'h1000 + 32'(c);
      chk("contention single good", {31'b0, data_good & instr_good}, 0);
      if (data_good) begin
        seen[ng] = 1'b0;
        ng++;
      end else if (instr_good) begin
        seen[ng] = 1'b1;
        ng++;
      end
    end
    chk("contention grants", ng, 3);
    chk("contention grant0", {31'b0, seen[0]}, 0);
    chk("contention grant1", {31'b0, seen[1]}, 1);
    chk("contention grant2", {31'b0, seen[2]}, 0);
    idle_inputs();
    step();
    step();

    // Asynchronous reset mid-transaction
    do_reset();
    data_write = 1'b1;
    data_adr   = 32'h900;
    data_wdata = 32'hA5A5A5A5;
    step();
    chk("midrst busy bus_write", {31'b0, bus_write}, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_quiet("midrst async");
    chk("midrst bus_adr",   bus_adr,   0);
    chk("midrst bus_wdata", bus_wdata, 0);
    data_write = 1'b0;
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk_quiet($sformatf("midrst post c%0d", c));
    end
    data_read = 1'b1;
    data_adr  = 32'hA00;
    step();
    chk("midrst fresh bus_read", {31'b0, bus_read}, 1);
    chk("midrst fresh bus_adr",  bus_adr, 32'hA00);
    bus_ack   = 1'b1;
    bus_rdata = 32'h5151A0A0;
    step();
    idle_inputs();
    chk("midrst fresh data_good",  {31'b0, data_good}, 1);
    chk("midrst fresh data_rdata", data_rdata, 32'h5151A0A0);
    step();

    // Stray ack in IDLE
    bus_ack   = 1'b1;
    bus_rdata = 32'hFFFF0000;
    step();
    bus_ack   = 1'b0;
    bus_rdata = '0;
    chk_quiet("stray c1");
    step();
    chk_quiet("stray c2");
    instr_read = 1'b1;
    instr_adr  = 32'hB00;
    step();
    chk("stray next bus_read", {31'b0, bus_read}, 1);
    chk("stray next bus_adr",  bus_adr, 32'hB00);
    bus_ack   = 1'b1;
    bus_rdata = 32'h0000B00B;
    step();
    idle_inputs();
    chk("stray next instr_good",  {31'b0, instr_good}, 1);
    chk("stray next instr_rdata", instr_rdata, 32'h0000B00B);
    step();

    // Watchdog
    instr_read = 1'b1;
    instr_adr  = 32'hC00;
    step();
`ifdef MEM_ARB_TIMEOUT_EN
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("wd c%0d bus_read", c), {31'b0, bus_read}, 1);
      chk($sformatf("wd c%0d timeout", c),  {31'b0, timeout},  0);
      chk($sformatf("wd c%0d goods", c), {30'b0, data_good, instr_good}, 0);
      step();
    end
    instr_read = 1'b0;
    chk("wd abort bus_read",    {31'b0, bus_read},   0);
    chk("wd abort instr_good",  {31'b0, instr_good}, 1);
    chk("wd abort timeout",     {31'b0, timeout},    1);
    chk("wd abort instr_rdata", instr_rdata, 32'hBAD0BAD0);
    step();
    chk("wd after timeout", {31'b0, timeout}, 0);
    chk_quiet("wd after");
    // Ack in the expiry cycle completes normally
    data_read = 1'b1;
    data_adr  = 32'hD00;
    step();
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin
        bus_ack   = 1'b1;
        bus_rdata = 32'h77777777;
      end
      step();
    end
    idle_inputs();
    chk("wd race data_good",  {31'b0, data_good}, 1);
    chk("wd race data_rdata", data_rdata, 32'h77777777);
    chk("wd race timeout",    {31'b0, timeout}, 0);
    step();
`else
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("nowd c%0d bus_read", c), {31'b0, bus_read}, 1);
      chk($sformatf("nowd c%0d timeout", c),  {31'b0, timeout},  0);
      chk($sformatf("nowd c%0d goods", c), {30'b0, data_good, instr_good}, 0);
      if (c == 10) begin
        bus_ack   = 1'b1;
        bus_rdata = 32'h0C0C0C0C;
      end
      step();
    end
    idle_inputs();
    chk("nowd instr_good",  {31'b0, instr_good}, 1);
    chk("nowd instr_rdata", instr_rdata, 32'h0C0C0C0C);
    step();
`endif

    // Randomized traffic against a transaction-level model
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    d_pend     = 1'b0;
    i_pend     = 1'b0;
    d_isrd     = 1'b0;
    d_both     = 1'b0;
    last_instr = 1'b1;
    inflight   = 1'b0;
    n_done     = 0;
    age        = 0;
    for (int c = 0; c < 3000; c++) begin
      step();
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
      strobe    = bus_read | bus_write;

      if (strobe && !inflight) begin
        chk("rand grant with request", {31'b0, d_pend | i_pend}, 1);
        exp_i     = i_pend && (!d_pend || !last_instr);
        own_instr = exp_i;
        own_rd    = exp_i ? 1'b1 : d_isrd;
        own_adr   = exp_i ? i_adr_m : d_adr_m;
        own_wd    = exp_i ? 32'h0 : d_wd_m;
        inflight  = 1'b1;
        cd        = $urandom_range(1, 3);
        age       = 0;
      end
      if (inflight && strobe) begin
        chk("rand bus_read",  {31'b0, bus_read},  {31'b0, own_rd});
        chk("rand bus_write", {31'b0, bus_write}, {31'b0, !own_rd});
        chk("rand bus_adr",   bus_adr,   own_adr);
        chk("rand bus_wdata", bus_wdata, own_wd);
        cd--;
        if (cd == 0) begin
          bus_ack = 1'b1;
          widx    = own_adr[5:2];
          if (own_rd) begin
            bus_rdata = mem[widx];
            exp_rd    = mem[widx];
          end else begin
            mem[widx] = own_wd;
            exp_rd    = 32'h0;
          end
        end
      end

      chk("rand single good", {31'b0, data_good & instr_good}, 0);
      chk("rand timeout", {31'b0, timeout}, 0);
      if (data_good || instr_good) begin
        chk("rand good after grant", {31'b0, inflight}, 1);
        chk("rand good side", {31'b0, instr_good}, {31'b0, own_instr});
        chk("rand data_rdata",  data_rdata,  own_instr ? 32'h0 : exp_rd);
        chk("rand instr_rdata", instr_rdata, own_instr ? exp_rd : 32'h0);
        if (own_instr) i_pend = 1'b0;
        else           d_pend = 1'b0;
        last_instr = own_instr;
        inflight   = 1'b0;
        n_done++;
      end else begin
        chk("rand idle rdata", data_rdata | instr_rdata, 0);
        if (inflight) begin
          age++;
          if (age > 8) begin
            chk("rand completion bound", age, 0);
            inflight = 1'b0;
          end
        end
      end

      if (!d_pend && $urandom_range(0, 3) == 0) begin
        d_pend  = 1'b1;
        d_isrd  = 1'($urandom_range(0, 1));
        d_both  = 1'($urandom_range(0, 1));
        d_adr_m = 32'h1000 | (32'($urandom_range(0, 15)) << 2);
        d_wd_m  = $urandom;
      end
      if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend  = 1'b1;
        i_adr_m = 32'h1000 | (32'($urandom_range(0, 15)) << 2);
      end
      data_read  = d_pend && d_isrd;
      data_write = d_pend && (!d_isrd || d_both);
      data_adr   = d_pend ? d_adr_m : $urandom;
      data_wdata = d_pend ? d_wd_m : $urandom;
      instr_read = i_pend;
      instr_adr  = i_pend ? i_adr_m : $urandom;
    end
    chk("rand progress", {31'b0, n_done > 100}, 1);
    idle_inputs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Downstream stage of `data_memory` and the instruction fetch unit: arbitrates their requests onto a single external memory bus and returns read data plus a one-cycle `*_good` completion strobe to the winning requester. One transaction is outstanding at a time. Arbitration is round-robin. Bus-side outputs are registered. An optional watchdog aborts hung bus transactions.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum busy cycles without ack before abort. Used only with `MEM_ARB_TIMEOUT_EN`. Legal range is 2..65535.
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `data_read`  in  1  data-side read request, level
- `data_write`  in  1  data-side write request, level
- `data_adr`  in  32  data-side address
- `data_wdata`  in  32  data-side write data
- `data_good`  out  1  data transaction complete, 1-cycle pulse
- `data_rdata`  out  32  data read result, valid while `data_good`=1
- `instr_read`  in  1  fetch request, level
- `instr_adr`  in  32  fetch address
- `instr_good`  out  1  fetch complete, 1-cycle pulse
- `instr_rdata`  out  32  fetched word, valid while `instr_good`=1
- `bus_read`  out  1  bus read strobe, held for the whole transaction
- `bus_write`  out  1  bus write strobe, held for the whole transaction
- `bus_adr`  out  32  bus address
- `bus_wdata`  out  32  bus write data
- `bus_ack`  in  1  bus completion, 1-cycle pulse; `bus_rdata` valid in the same cycle
- `bus_rdata`  in  32  bus read data
- `timeout`  out  1  1-cycle pulse when a transaction is aborted

## Operation
- FSM states:
  - IDLE: sample requests.
  - BUSY: bus strobe held, waiting for `bus_ack`.
  - RESP: drive `*_good` for one cycle.
- Pending requests are `dreq = data_read|data_write` and `ireq = instr_read`.
- IDLE transitions:
  - Neither pending: stay in IDLE.
  - Exactly one pending: grant it.
  - Both pending: grant the side not granted last (`last_grant` flag, reset value = instr, so data wins first).
- On grant:
  - Latch the requester's address and write data into `bus_adr`/`bus_wdata`.
  - Latch the operation and the owner.
  - Move to BUSY.
- Data side with `data_read` and `data_write` both high: read wins; write is ignored for that grant.
- Instruction grants are always reads. `bus_wdata` is 0 during instruction grants.
- BUSY: `bus_read` xor `bus_write` is held at 1, and `bus_adr`/`bus_wdata` stay stable. On `bus_ack`:
  - Capture `bus_rdata` (reads; writes capture 0).
  - Clear the bus strobes.
  - Move to RESP.
- RESP:
  - Assert the owner's `*_good` for exactly one cycle with captured data on its `*_rdata`.
  - Update `last_grant`.
  - Return to IDLE.
- `*_rdata` of the non-owner is 0 at all times. The owner's `*_rdata` is 0 outside RESP.
- A requester dropping its request while BUSY does not cancel the transaction; its `*_good` still pulses.
- A `bus_ack` received in IDLE or RESP is ignored.

## Timing
- Reset values: every output is 0, state is IDLE, `last_grant` = instr.
- Reset applies asynchronously mid-transaction: strobes drop immediately with no `*_good`.
- Latency for a request seen in IDLE at cycle 0:
  - `bus_*` is asserted from cycle 1.
  - With `bus_ack` at cycle k≥1, strobes are low at k+1 and `*_good` is high during k+1.
  - Next grant is possible at k+2 with strobes at k+3.
  - Minimum request-to-good latency is 2 cycles.
- `data_good`/`data_rdata` are registered and valid for a full cycle. This lets a combinational consumer capture them, and a registered requester deasserts before the next IDLE sample.
- A request still high in the IDLE cycle after RESP is treated as a new request. Requesters must drop their request in the cycle after `*_good`.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on grant and increments each BUSY cycle without `bus_ack`.
  - When the counter equals `TIMEOUT_CYCLES-1` with no ack, the strobes drop and the FSM enters RESP with `*_rdata` = 32'hBAD0_BAD0. `*_good` and `timeout` pulse together.
  - An ack in the same cycle as expiry wins and is treated as a normal completion.
- `MEM_ARB_TIMEOUT_EN` undefined: no counter, `timeout` tied 0, BUSY waits indefinitely.

## Test plan
- Data read: `data_read`=1, `data_adr`=0x100, ack at cycle 3 with `bus_rdata`=0xCAFEF00D -> `bus_read`=1 and `bus_adr`=0x100 in cycles 1–3; `data_good`=1 and `data_rdata`=0xCAFEF00D at cycle 4.
- Data write: `data_write`=1, `data_adr`=0x200, `data_wdata`=0x12345678, ack at cycle 1 -> `bus_write`=1 and `bus_wdata`=0x12345678 at cycle 1; `data_good` at cycle 2 with `data_rdata`=0.
- Contention: `data_read` and `instr_read` both held from reset, immediate acks -> grants alternate data, instr, data. `instr_good` never coincides with `data_good`.
- Reset mid-transaction: `rst` pulsed while BUSY -> all outputs 0 asynchronously, no `*_good`; a fresh request afterwards completes normally.
- Timeout (macro on, `TIMEOUT_CYCLES`=4): `instr_read` with no ack -> strobes high for cycles 1–4; `instr_good`=1, `timeout`=1, `instr_rdata`=0xBAD0BAD0 at cycle 5.
- Stray ack: `bus_ack` pulsed in IDLE -> no `*_good`, state unchanged.
